// File: rtl/ext_pkg.sv
// Shared encodings for the immediate-extension stage: mode codes and the
// occupancy view used by the pipeline control.
package ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_ZERO   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SIGN   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_HIGH   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BRANCH = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SHAMT  = 3'd4;

  // Occupancy of the stage: empty-or-one entry (output reg only) vs full
  // (output reg plus skid reg). Decoded directly from the skid valid bit.
  typedef enum logic {
    OCC_PART = 1'b0,
    OCC_FULL = 1'b1
  } occ_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate-extension stage: upstream valid/ready
// with imm/mode, downstream valid/ready with extended data and error flag.
interface imm_ext_pipe_if
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [MODE_W-1:0] in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_err;

  // Driver side: produces immediates and consumes results.
  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  // Stage side.
  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender. Kept free of state so other
// decoders can reuse it; the pipeline registers live in the caller.
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  data,
  output logic              err
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{EXT_W{1'b0}}, imm};
  assign sext = {{EXT_W{imm[IN_W-1]}}, imm};

  // Select the extension; unknown codes fall back to zero-extension and flag err.
  always_comb begin
    data = zext;
    err  = 1'b0;
    case (mode)
      MODE_ZERO:   data = zext;
      MODE_SIGN:   data = sext;
      MODE_HIGH:   data = {imm, {EXT_W{1'b0}}};
      MODE_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
      MODE_SHAMT:  data = {{(OUT_W-SHAMT_W){1'b0}}, imm[SHAMT_W-1:0]};
      default:     err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage (decode -> execute) with a 2-entry
// skid buffer: 1-cycle latency, full throughput, and in_ready driven only
// from state so there is no combinational path from out_ready.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_ext_pipe_if.slave bus
);

  if (!((IN_W + 2 <= OUT_W) && (SHAMT_W <= IN_W))) begin : g_param_check
    $error("imm_ext_pipe: need IN_W+2 <= OUT_W and SHAMT_W <= IN_W");
  end

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .data (ext_data),
    .err  (ext_err)
  );

  logic [OUT_W-1:0] out_data_reg;
  logic             out_err_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] skid_data_reg;
  logic             skid_err_reg;
  logic             skid_valid_reg;

  occ_e occ;
  logic accept;

  assign occ    = skid_valid_reg ? OCC_FULL : OCC_PART;
  assign accept = bus.in_valid & ~skid_valid_reg;

  assign bus.in_ready  = ~skid_valid_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_err   = out_err_reg;

  // Output/skid register control: flush drops everything, a full stage only
  // drains the skid, otherwise accepted entries go to the output reg unless
  // it is stalled, in which case they park in the skid reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_err_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      case (occ)
        OCC_FULL: begin
          if (bus.out_ready) begin
            out_data_reg   <= skid_data_reg;
            out_err_reg    <= skid_err_reg;
            skid_valid_reg <= 1'b0;
          end
        end
        OCC_PART: begin
          if (accept) begin
            if (!out_valid_reg || bus.out_ready) begin
              out_data_reg  <= ext_data;
              out_err_reg   <= ext_err;
              out_valid_reg <= 1'b1;
            end else begin
              skid_data_reg  <= ext_data;
              skid_err_reg   <= ext_err;
              skid_valid_reg <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= out_valid_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: mode sweep, backpressure, flush, async
// reset, a wide-parameter instance and a long random handshake run checked
// against a queue-based reference.
module tb_imm_ext_pipe;
  import ext_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_ext_pipe_if #(.IN_W(12), .OUT_W(64)) bus64 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(64), .SHAMT_W(5)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .bus   (bus64)
  );

  int   vec_cnt  = 0;
  int   miscmp   = 0;
  int   fire_cnt = 0;
  exp_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference extension for IN_W=16, OUT_W=32, SHAMT_W=5.
  function automatic exp_t ref_ext(input logic [15:0] imm, input logic [2:0] m);
    exp_t r;
    r.e = 1'b0;
    r.d = {16'h0000, imm};
    case (m)
      3'd0: r.d = r.d;
      3'd1: if (imm[15]) r.d = r.d | 32'hFFFF0000;
      3'd2: r.d = r.d << 16;
      3'd3: begin
        if (imm[15]) r.d = r.d | 32'hFFFF0000;
        r.d = r.d << 2;
      end
      3'd4: r.d = r.d & 32'h0000001F;
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // One clock of stimulus with model checks on occupancy and on every output transfer.
  task automatic cyc(input bit iv, input logic [15:0] imm, input logic [2:0] m,
                     input bit ordy, output bit acc);
    bit   fire;
    exp_t e;
    bus.in_valid  = iv;
    bus.in_imm    = imm;
    bus.in_mode   = m;
    bus.out_ready = ordy;
    vec_cnt++;
    if (bus.out_valid !== (exp_q.size() > 0)) begin
      miscmp++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, exp_q.size() > 0);
    end
    vec_cnt++;
    if (bus.in_ready !== (exp_q.size() < 2)) begin
      miscmp++;
      $display("FAIL in_ready: got %b expected %b", bus.in_ready, exp_q.size() < 2);
    end
    acc  = iv && (bus.in_ready === 1'b1);
    fire = (bus.out_valid === 1'b1) && ordy;
    if (fire) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miscmp++;
        $display("FAIL spurious_out: got %h with nothing expected", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        fire_cnt++;
        if ({bus.out_data, bus.out_err} !== {e.d, e.e}) begin
          miscmp++;
          $display("FAIL out_xfer: got %h err %b expected %h err %b",
                   bus.out_data, bus.out_err, e.d, e.e);
        end
      end
    end
    if (acc) exp_q.push_back(ref_ext(imm, m));
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_imm = '0; bus64.in_mode = '0; bus64.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_err, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      miscmp++;
      $display("FAIL reset_state: got v=%b d=%h e=%b rdy=%b expected v=0 d=0 e=0 rdy=1",
               bus.out_valid, bus.out_data, bus.out_err, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL post_reset: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_modes();
    logic [2:0]  modes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    logic [31:0] exp_d [6] = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                               32'hFFFE0004, 32'h00000001, 32'h00008001};
    logic        exp_e [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    bus.in_imm    = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = modes[i];
      step();
      vec_cnt++;
      if ({bus.out_valid, bus.out_data, bus.out_err} !== {1'b1, exp_d[i], exp_e[i]}) begin
        miscmp++;
        $display("FAIL mode_%0d: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                 modes[i], bus.out_valid, bus.out_data, bus.out_err, exp_d[i], exp_e[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL mode_drain: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    bit a;
    fire_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 3) begin
        vec_cnt++;
        if (bus.in_ready !== 1'b1) begin
          miscmp++;
          $display("FAIL bp_ready_before_stall: got %b expected 1", bus.in_ready);
        end
      end
      if (c == 4) begin
        vec_cnt++;
        if (bus.in_ready !== 1'b0) begin
          miscmp++;
          $display("FAIL bp_ready_drop: got %b expected 0", bus.in_ready);
        end
      end
      if (c >= 4 && c <= 7) begin
        vec_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000003) begin
          miscmp++;
          $display("FAIL bp_stall_hold: got v=%b d=%h expected v=1 d=00000003",
                   bus.out_valid, bus.out_data);
        end
      end
      if (c == 13) begin
        vec_cnt++;
        if (fire_cnt != 8 || exp_q.size() != 0) begin
          miscmp++;
          $display("FAIL bp_throughput: got %0d delivered %0d pending expected 8 delivered 0 pending",
                   fire_cnt, exp_q.size());
        end
      end
      cyc(nxt <= 8, 16'(nxt), MODE_SIGN, !(c >= 3 && c <= 6), a);
      if (a) nxt++;
    end
  endtask

  task automatic test_flush();
    bit a;
    cyc(1'b1, 16'h0011, MODE_SIGN, 1'b0, a);
    cyc(1'b1, 16'h0022, MODE_SIGN, 1'b0, a);
    vec_cnt++;
    if (bus.in_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL flush_setup_full: got in_ready=%b expected 0", bus.in_ready);
    end
    flush = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_imm    = 16'h0033;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscmp++;
      $display("FAIL flush_clear: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    cyc(1'b0, 16'h0000, MODE_ZERO, 1'b1, a);
    cyc(1'b1, 16'h0044, MODE_ZERO, 1'b1, a);
    cyc(1'b0, 16'h0000, MODE_ZERO, 1'b1, a);
  endtask

  task automatic test_async_reset();
    bit a;
    cyc(1'b1, 16'h00AA, 3'd7, 1'b0, a);
    cyc(1'b1, 16'h00BB, MODE_ZERO, 1'b0, a);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vec_cnt++;
    if ({bus.out_valid, bus.out_data, bus.out_err, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      miscmp++;
      $display("FAIL async_reset: got v=%b d=%h e=%b rdy=%b expected v=0 d=0 e=0 rdy=1",
               bus.out_valid, bus.out_data, bus.out_err, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    step();
    vec_cnt++;
    if (bus.out_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL reset_held_edge: got out_valid=%b expected 0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cyc(1'b1, 16'h1234, MODE_SIGN, 1'b1, a);
    cyc(1'b0, 16'h0000, MODE_ZERO, 1'b1, a);
  endtask

  task automatic test_wide_params();
    bus64.out_ready = 1'b1;
    bus64.in_valid  = 1'b1;
    bus64.in_imm    = 12'h800;
    bus64.in_mode   = MODE_SIGN;
    step();
    vec_cnt++;
    if (bus64.out_valid !== 1'b1 || bus64.out_data !== 64'hFFFFFFFFFFFFF800) begin
      miscmp++;
      $display("FAIL wide_sign: got v=%b d=%h expected v=1 d=fffffffffffff800",
               bus64.out_valid, bus64.out_data);
    end
    bus64.in_mode = MODE_HIGH;
    step();
    vec_cnt++;
    if (bus64.out_valid !== 1'b1 || bus64.out_data !== 64'h8000000000000000) begin
      miscmp++;
      $display("FAIL wide_high: got v=%b d=%h expected v=1 d=8000000000000000",
               bus64.out_valid, bus64.out_data);
    end
    bus64.in_valid = 1'b0;
    step();
    vec_cnt++;
    if (bus64.out_valid !== 1'b0) begin
      miscmp++;
      $display("FAIL wide_drain: got out_valid=%b expected 0", bus64.out_valid);
    end
  endtask

  task automatic test_random();
    int sent  = 0;
    int cyc_n = 0;
    bit a;
    bit iv;
    fire_cnt = 0;
    while ((sent < 10000 || exp_q.size() > 0) && cyc_n < 60000) begin
      iv = (sent < 10000) && ($urandom_range(0, 3) != 0);
      cyc(iv, 16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, a);
      if (a) sent++;
      cyc_n++;
    end
    vec_cnt++;
    if (fire_cnt != 10000 || exp_q.size() != 0) begin
      miscmp++;
      $display("FAIL random_count: got %0d delivered %0d pending expected 10000 delivered 0 pending",
               fire_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wide_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
